// File: rtl/uart_pkg.sv
// Shared UART constants and FIFO index types.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int FIFO_ADDR_W = 4;

  // Pointer into the receive FIFO and a fill level that can reach DEPTH.
  typedef logic [FIFO_ADDR_W-1:0] fifo_ptr_t;
  typedef logic [FIFO_ADDR_W:0]   fifo_cnt_t;

endpackage

// File: rtl/fifo_ram_module.sv
// Simple dual-port RAM, DEPTH x DATA_W.
// Synchronous write; the read port registers the addressed word only when
// re is high, so rd_data holds the last popped word between reads.
module fifo_ram_module #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array: written on an accepted write, never reset.
  always_ff @(posedge CLK) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Output register: read-before-write, so a same-address write/read pair
  // returns the old word.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)  rd_data <= '0;
    else if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/rx_fifo_module.sv
// Receive buffer behind the UART receive controller.
// Optional feature macro: RX_FIFO_ALMOST_FULL_EN adds a registered
// Almost_Full output (Count >= AF_LEVEL).
//
// Read handshake: the consumer raises Rd_Req for one CLK per byte; the
// request is taken only while Empty is low. A taken request pulses Rd_Valid
// on the following CLK with the byte on Rd_Data. Requests made while Empty
// are dropped and leave Rd_Data unchanged.
module rx_fifo_module
  import uart_pkg::*;
#(
  parameter int ADDR_W = FIFO_ADDR_W,
  parameter int DATA_W = UART_DATA_W
`ifdef RX_FIFO_ALMOST_FULL_EN
  ,
  parameter int AF_LEVEL = 12
`endif
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              Rx_Done_Sig,
  input  logic [DATA_W-1:0] Rx_Data,
  output logic              Rx_En_Sig,
  input  logic              Rd_Req,
  output logic [DATA_W-1:0] Rd_Data,
  output logic              Rd_Valid,
  output logic              Empty,
  output logic              Full,
  output logic [ADDR_W:0]   Count,
  input  logic              Ovf_Clr,
  output logic              Overflow_Sig
`ifdef RX_FIFO_ALMOST_FULL_EN
  ,
  output logic              Almost_Full
`endif
);

  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic              done_q;
  logic              we;
  logic              re;
  logic              wr_accept;
  logic              ovf_set;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_next;

  // Strobes: one write per Rx_Done_Sig rising edge; a full FIFO still
  // accepts the write when a read frees a slot in the same CLK.
  always_comb begin
    we         = Rx_Done_Sig & ~done_q;
    re         = Rd_Req & ~Empty;
    wr_accept  = we & (~Full | re);
    ovf_set    = we & Full & ~re;
    count_next = Count;
    case ({wr_accept, re})
      2'b10:   count_next = Count + (ADDR_W+1)'(1);
      2'b01:   count_next = Count - (ADDR_W+1)'(1);
      default: count_next = Count;
    endcase
  end

  // Receiver enable comes up one CLK after reset release and stays up;
  // the previous Rx_Done_Sig is kept for edge detection.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      Rx_En_Sig <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      Rx_En_Sig <= 1'b1;
      done_q    <= Rx_Done_Sig;
    end
  end

  // Circular pointers, wrapping naturally at DEPTH.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (re)        rd_ptr <= rd_ptr + ADDR_W'(1);
    end
  end

  // Fill level and flags, all derived from the same next count.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      Count <= '0;
      Empty <= 1'b1;
      Full  <= 1'b0;
    end else begin
      Count <= count_next;
      Empty <= (count_next == '0);
      Full  <= (count_next == DEPTH_CNT);
    end
  end

  // Sticky overflow; a new drop beats a clear in the same CLK.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)       Overflow_Sig <= 1'b0;
    else if (ovf_set) Overflow_Sig <= 1'b1;
    else if (Ovf_Clr) Overflow_Sig <= 1'b0;
  end

  // Read data qualifier, one CLK behind the accepted request.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) Rd_Valid <= 1'b0;
    else        Rd_Valid <= re;
  end

`ifdef RX_FIFO_ALMOST_FULL_EN
  // Almost-full flag tracks the registered Count.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) Almost_Full <= 1'b0;
    else        Almost_Full <= (count_next >= (ADDR_W+1)'(AF_LEVEL));
  end
`endif

  fifo_ram_module #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .we      (wr_accept),
    .wr_addr (wr_ptr),
    .wr_data (Rx_Data),
    .re      (re),
    .rd_addr (rd_ptr),
    .rd_data (Rd_Data)
  );

endmodule

// File: tb/tb_rx_fifo_module.sv
// Self-checking bench for rx_fifo_module (default 16 x 8 configuration).
// Optional feature macro: RX_FIFO_ALMOST_FULL_EN enables Almost_Full checks.
module tb_rx_fifo_module;
  import uart_pkg::*;

  localparam int DEPTH = 16;

  // Clock / reset
  logic       CLK = 1'b0;
  logic       RST_n;
  logic       Rx_Done_Sig = 1'b0;
  logic [7:0] Rx_Data = 8'h00;
  logic       Rd_Req = 1'b0;
  logic       Ovf_Clr = 1'b0;
  logic       Rx_En_Sig;
  logic [7:0] Rd_Data;
  logic       Rd_Valid;
  logic       Empty;
  logic       Full;
  fifo_cnt_t  Count;
  logic       Overflow_Sig;
`ifdef RX_FIFO_ALMOST_FULL_EN
  logic       Almost_Full;
`endif

  always #5 CLK = ~CLK;

  rx_fifo_module dut (
    .CLK          (CLK),
    .RST_n        (RST_n),
    .Rx_Done_Sig  (Rx_Done_Sig),
    .Rx_Data      (Rx_Data),
    .Rx_En_Sig    (Rx_En_Sig),
    .Rd_Req       (Rd_Req),
    .Rd_Data      (Rd_Data),
    .Rd_Valid     (Rd_Valid),
    .Empty        (Empty),
    .Full         (Full),
    .Count        (Count),
    .Ovf_Clr      (Ovf_Clr),
    .Overflow_Sig (Overflow_Sig)
`ifdef RX_FIFO_ALMOST_FULL_EN
    ,
    .Almost_Full  (Almost_Full)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of stored bytes plus the visible registers.
  logic [7:0] exp_q[$];
  logic       m_prev_done;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ovf;
  logic       m_rx_en;

  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      exp_q.delete();
      m_prev_done = 1'b0;
      m_valid     = 1'b0;
      m_data      = 8'h00;
      m_ovf       = 1'b0;
      m_rx_en     = 1'b0;
    end else begin
      logic wr, rd, drop;
      wr   = Rx_Done_Sig && !m_prev_done;
      rd   = Rd_Req && (exp_q.size() > 0);
      drop = 1'b0;
      m_rx_en = 1'b1;
      m_valid = rd;
      if (rd) m_data = exp_q.pop_front();
      if (wr) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(Rx_Data);
        else                      drop = 1'b1;
      end
      if (drop)         m_ovf = 1'b1;
      else if (Ovf_Clr) m_ovf = 1'b0;
      m_prev_done = Rx_Done_Sig;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge CLK) begin
    check("cmp_count", 32'(Count), 32'(exp_q.size()));
    check("cmp_empty", 32'(Empty), 32'(exp_q.size() == 0));
    check("cmp_full", 32'(Full), 32'(exp_q.size() == DEPTH));
    check("cmp_valid", 32'(Rd_Valid), 32'(m_valid));
    check("cmp_data", 32'(Rd_Data), 32'(m_data));
    check("cmp_ovf", 32'(Overflow_Sig), 32'(m_ovf));
    check("cmp_rx_en", 32'(Rx_En_Sig), 32'(m_rx_en));
`ifdef RX_FIFO_ALMOST_FULL_EN
    check("cmp_af", 32'(Almost_Full), 32'(exp_q.size() >= 12));
`endif
  end

  // Driver tasks
  task automatic write_byte(input logic [7:0] b);
    Rx_Data     = b;
    Rx_Done_Sig = 1'b1;
    @(negedge CLK);
    Rx_Done_Sig = 1'b0;
    @(negedge CLK);
  endtask

  task automatic read_check(input string name, input logic [7:0] exp);
    Rd_Req = 1'b1;
    @(negedge CLK);
    Rd_Req = 1'b0;
    check({name, "_valid"}, 32'(Rd_Valid), 32'd1);
    check({name, "_data"}, 32'(Rd_Data), 32'(exp));
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    // 1. Reset, then single frame
    RST_n = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_count", 32'(Count), 32'd0);
    check("rst_empty", 32'(Empty), 32'd1);
    check("rst_full", 32'(Full), 32'd0);
    check("rst_rx_en", 32'(Rx_En_Sig), 32'd0);
    check("rst_rd_data", 32'(Rd_Data), 32'd0);
    check("rst_ovf", 32'(Overflow_Sig), 32'd0);
    RST_n = 1'b1;
    @(negedge CLK);
    check("rx_en_up", 32'(Rx_En_Sig), 32'd1);
    write_byte(8'hA5);
    check("t1_count", 32'(Count), 32'd1);
    check("t1_empty", 32'(Empty), 32'd0);
    read_check("t1_rd", 8'hA5);
    check("t1_count0", 32'(Count), 32'd0);
    check("t1_empty1", 32'(Empty), 32'd1);

    // 2. Fill and wrap
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    check("t2_full", 32'(Full), 32'd1);
    check("t2_count", 32'(Count), 32'd16);
    for (int i = 0; i < 16; i++) read_check("t2_rd", 8'(i));
    check("t2_empty", 32'(Empty), 32'd1);
    for (int i = 0; i < 3; i++) write_byte(8'h20 + 8'(i));
    for (int i = 0; i < 3; i++) read_check("t2_wrap", 8'h20 + 8'(i));

    // 3. Overflow
    for (int i = 0; i < 16; i++) write_byte(8'h30 + 8'(i));
    write_byte(8'hFF);
    check("t3_ovf", 32'(Overflow_Sig), 32'd1);
    check("t3_count", 32'(Count), 32'd16);
    Ovf_Clr = 1'b1;
    @(negedge CLK);
    Ovf_Clr = 1'b0;
    check("t3_ovf_clr", 32'(Overflow_Sig), 32'd0);
    // Clear and a new drop in the same CLK: the drop wins.
    Rx_Data = 8'hFE; Rx_Done_Sig = 1'b1; Ovf_Clr = 1'b1;
    @(negedge CLK);
    Rx_Done_Sig = 1'b0; Ovf_Clr = 1'b0;
    check("t3_set_wins", 32'(Overflow_Sig), 32'd1);
    @(negedge CLK);
    Ovf_Clr = 1'b1;
    @(negedge CLK);
    Ovf_Clr = 1'b0;
    check("t3_ovf_clr2", 32'(Overflow_Sig), 32'd0);

    // 4. Simultaneous write and read while full, then while empty
    Rx_Data = 8'h77; Rx_Done_Sig = 1'b1; Rd_Req = 1'b1;
    @(negedge CLK);
    Rx_Done_Sig = 1'b0; Rd_Req = 1'b0;
    check("t4_full_count", 32'(Count), 32'd16);
    check("t4_full_ovf", 32'(Overflow_Sig), 32'd0);
    check("t4_full_data", 32'(Rd_Data), 32'h30);
    for (int i = 1; i < 16; i++) read_check("t4_drain", 8'h30 + 8'(i));
    read_check("t4_last", 8'h77);
    check("t4_empty", 32'(Empty), 32'd1);
    Rx_Data = 8'h88; Rx_Done_Sig = 1'b1; Rd_Req = 1'b1;
    @(negedge CLK);
    Rx_Done_Sig = 1'b0; Rd_Req = 1'b0;
    check("t4_empty_count", 32'(Count), 32'd1);
    check("t4_empty_valid", 32'(Rd_Valid), 32'd0);
    read_check("t4_empty_rd", 8'h88);

    // 5. Read while empty, long done pulse
    Rd_Req = 1'b1;
    @(negedge CLK);
    Rd_Req = 1'b0;
    check("t5_empty_valid", 32'(Rd_Valid), 32'd0);
    check("t5_empty_hold", 32'(Rd_Data), 32'h88);
    Rx_Data = 8'h99; Rx_Done_Sig = 1'b1;
    repeat (3) @(negedge CLK);
    Rx_Done_Sig = 1'b0;
    @(negedge CLK);
    check("t5_long_count", 32'(Count), 32'd1);
    read_check("t5_long_rd", 8'h99);
    check("t5_long_empty", 32'(Empty), 32'd1);

    // 6. Reset mid-operation
    for (int i = 0; i < 5; i++) write_byte(8'h50 + 8'(i));
    check("t6_count5", 32'(Count), 32'd5);
    #2 RST_n = 1'b0;
    #1;
    check("t6_rst_count", 32'(Count), 32'd0);
    check("t6_rst_empty", 32'(Empty), 32'd1);
    check("t6_rst_rx_en", 32'(Rx_En_Sig), 32'd0);
    @(negedge CLK);
    RST_n = 1'b1;
    @(negedge CLK);
    check("t6_rx_en_up", 32'(Rx_En_Sig), 32'd1);

    // Almost-full threshold crossing
    for (int i = 0; i < 11; i++) write_byte(8'h60 + 8'(i));
    check("t6_count11", 32'(Count), 32'd11);
`ifdef RX_FIFO_ALMOST_FULL_EN
    check("t6_af_11", 32'(Almost_Full), 32'd0);
`endif
    write_byte(8'h6B);
    check("t6_count12", 32'(Count), 32'd12);
`ifdef RX_FIFO_ALMOST_FULL_EN
    check("t6_af_12", 32'(Almost_Full), 32'd1);
`endif
    read_check("t6_af_rd", 8'h60);
`ifdef RX_FIFO_ALMOST_FULL_EN
    check("t6_af_fall", 32'(Almost_Full), 32'd0);
`endif
    for (int i = 1; i < 12; i++) read_check("t6_drain", 8'h60 + 8'(i));
    @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
